// File: rtl/lspc_timer.sv
// Programmable raster down-counter that raises a short TIMER_IRQ pulse on expiry.
// Optional border-line stall is compiled in when the TIMER_STOP_EN macro is defined.
module lspc_timer #(
    parameter int CNT_WIDTH = 32,
    parameter int PULSE_LEN = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        PIXEL_EN,
    input  logic        REG_WR_HI,
    input  logic        REG_WR_LO,
    input  logic        MODE_WR,
    input  logic [15:0] DATA_IN,
    input  logic        VBLANK_START,
    input  logic        LINE_BORDER,
    output logic        TIMER_IRQ,
    output logic        CNT_ZERO
);

    logic [CNT_WIDTH-1:0] reload_reg, reload_next;
    logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
    logic                 irq_en_reg, reload_wr_reg, reload_vbl_reg, reload_zero_reg;
    logic [2:0]           pulse_cnt_reg, pulse_cnt_next;
    logic                 stall;
    logic                 expiry;

`ifdef TIMER_STOP_EN
    logic stop_en_reg;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            stop_en_reg <= 1'b0;
        end else if (MODE_WR) begin
            stop_en_reg <= DATA_IN[8];
        end
    end

    assign stall = stop_en_reg & LINE_BORDER;
`else
    logic unused_line_border;

    assign unused_line_border = LINE_BORDER;
    assign stall = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            irq_en_reg      <= 1'b0;
            reload_wr_reg   <= 1'b0;
            reload_vbl_reg  <= 1'b0;
            reload_zero_reg <= 1'b0;
        end else if (MODE_WR) begin
            irq_en_reg      <= DATA_IN[4];
            reload_wr_reg   <= DATA_IN[5];
            reload_vbl_reg  <= DATA_IN[6];
            reload_zero_reg <= DATA_IN[7];
        end
    end

    // reload_next is the value after this cycle's writes, so a same-cycle HI+LO load sees both halves.
    always_comb begin
        reload_next = reload_reg;
        if (REG_WR_HI) begin
            reload_next[CNT_WIDTH-1:16] = DATA_IN[CNT_WIDTH-17:0];
        end
        if (REG_WR_LO) begin
            reload_next[15:0] = DATA_IN;
        end
    end

    assign CNT_ZERO = (cnt_reg == '0);

    // Loads take priority over ticking and swallow any expiry in the same cycle.
    always_comb begin
        cnt_next = cnt_reg;
        expiry   = 1'b0;
        if (REG_WR_LO && reload_wr_reg) begin
            cnt_next = reload_next;
        end else if (VBLANK_START && reload_vbl_reg) begin
            cnt_next = reload_reg;
        end else if (PIXEL_EN && !stall) begin
            if (CNT_ZERO) begin
                expiry   = 1'b1;
                cnt_next = reload_zero_reg ? reload_reg : '1;
            end else begin
                cnt_next = cnt_reg - 1'b1;
            end
        end
    end

    // A fresh expiry restarts the pulse length, so back-to-back expiries keep TIMER_IRQ high.
    always_comb begin
        pulse_cnt_next = pulse_cnt_reg;
        if (expiry && irq_en_reg) begin
            pulse_cnt_next = 3'(PULSE_LEN);
        end else if (pulse_cnt_reg != 3'd0) begin
            pulse_cnt_next = pulse_cnt_reg - 3'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            reload_reg    <= '0;
            cnt_reg       <= '0;
            pulse_cnt_reg <= 3'd0;
        end else begin
            reload_reg    <= reload_next;
            cnt_reg       <= cnt_next;
            pulse_cnt_reg <= pulse_cnt_next;
        end
    end

    assign TIMER_IRQ = (pulse_cnt_reg != 3'd0);

endmodule
